// File: rtl/cc_cond_unit_if.sv
// Execute-stage bundle between the pipeline and the condition-code unit.
// Valid/ready note: in_valid qualifies the instruction fields; there is no ready, the unit always accepts.
interface cc_cond_unit_if;
    logic       in_valid;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [0:2] alu_cc;
    logic       freeze;
    logic       err;
    logic [0:2] cc;
    logic       cnd;
    logic       e_cnd;
    logic       cc_wr;
    logic       stopped;

    modport master (
        output in_valid, icode, ifun, alu_cc, freeze, err,
        input  cc, cnd, e_cnd, cc_wr, stopped
    );

    modport slave (
        input  in_valid, icode, ifun, alu_cc, freeze, err,
        output cc, cnd, e_cnd, cc_wr, stopped
    );
endinterface

// File: rtl/cc_cond_unit.sv
// Condition-code register and jXX/cmovXX evaluator; flag updates stop for good
// once a halt or faulting instruction reaches execute, until reset.
module cc_cond_unit #(
    parameter logic [3:0] OPQ_CODE  = 4'h6,
    parameter logic [3:0] HALT_CODE = 4'h0,
    parameter logic [0:2] CC_RESET  = 3'b100
) (
    input  logic          clk,
    input  logic          rst,
    cc_cond_unit_if.slave bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_STOPPED = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [0:2] r_cc;
    logic       r_e_cnd;
    logic       r_cc_wr;
    logic       w_cnd;
    logic       w_x;
    logic       w_run;
    logic       w_cc_we;

    assign w_run   = (r_state == ST_RUN);
    // Faulting OPq never writes: err blocks the write as well as stopping the FSM.
    assign w_cc_we = w_run && bus.in_valid && (bus.icode == OPQ_CODE)
                     && !bus.freeze && !bus.err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.in_valid && ((bus.icode == HALT_CODE) || bus.err))
                    w_state_nxt = ST_STOPPED;
            end
            ST_STOPPED: w_state_nxt = ST_STOPPED;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Bit order: [0]=ZF, [1]=SF, [2]=OF.
    assign w_x = r_cc[1] ^ r_cc[2];

    always_comb begin
        w_cnd = 1'b0;
        case (bus.ifun)
            4'd0:    w_cnd = 1'b1;
            4'd1:    w_cnd = w_x | r_cc[0];
            4'd2:    w_cnd = w_x;
            4'd3:    w_cnd = r_cc[0];
            4'd4:    w_cnd = ~r_cc[0];
            4'd5:    w_cnd = ~w_x;
            4'd6:    w_cnd = ~w_x & ~r_cc[0];
            default: w_cnd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc    <= CC_RESET;
            r_cc_wr <= 1'b0;
            r_e_cnd <= 1'b0;
        end else begin
            r_cc_wr <= w_cc_we;
            if (w_cc_we)
                r_cc <= bus.alu_cc;
            if (w_run && bus.in_valid)
                r_e_cnd <= w_cnd;
        end
    end

    assign bus.cc      = r_cc;
    assign bus.cnd     = w_cnd;
    assign bus.e_cnd   = r_e_cnd;
    assign bus.cc_wr   = r_cc_wr;
    assign bus.stopped = (r_state == ST_STOPPED);
endmodule

// File: tb/tb_cc_cond_unit.sv
// Bench for cc_cond_unit: directed scenarios plus randomized traffic against a flag-level model.
module tb_cc_cond_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    cc_cond_unit_if bus ();

    cc_cond_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: flags kept as named booleans rather than a packed vector.
    bit m_zf, m_sf, m_of;
    bit m_e_cnd, m_cc_wr, m_stopped;

    function automatic bit ref_cnd(input bit zf, input bit sf, input bit of_, input int fn);
        bit less;
        bit equal;
        less  = (sf != of_);
        equal = zf;
        case (fn)
            0:       return 1'b1;
            1:       return less || equal;
            2:       return less;
            3:       return equal;
            4:       return !equal;
            5:       return !less;
            6:       return !less && !equal;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] m_cc_vec();
        return {m_zf, m_sf, m_of};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cc"},      32'(bus.cc),      32'(m_cc_vec()));
        check({tag, ".cnd"},     32'(bus.cnd),     32'(ref_cnd(m_zf, m_sf, m_of, int'(bus.ifun))));
        check({tag, ".e_cnd"},   32'(bus.e_cnd),   32'(m_e_cnd));
        check({tag, ".cc_wr"},   32'(bus.cc_wr),   32'(m_cc_wr));
        check({tag, ".stopped"}, 32'(bus.stopped), 32'(m_stopped));
    endtask

    task automatic m_reset();
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m_e_cnd = 1'b0; m_cc_wr = 1'b0; m_stopped = 1'b0;
    endtask

    // Advance one clock: the model consumes the inputs presented before the edge.
    task automatic step();
        bit wr;
        logic [0:2] a;
        a  = bus.alu_cc;
        wr = !m_stopped && bus.in_valid && (bus.icode == 4'h6) && !bus.freeze && !bus.err;
        if (!m_stopped && bus.in_valid)
            m_e_cnd = ref_cnd(m_zf, m_sf, m_of, int'(bus.ifun));
        m_cc_wr = wr;
        if (wr) begin
            m_zf = a[0]; m_sf = a[1]; m_of = a[2];
        end
        if (!m_stopped && bus.in_valid && ((bus.icode == 4'h0) || bus.err))
            m_stopped = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [0:2] a, input bit frz, input bit e);
        bus.in_valid = v;
        bus.icode    = ic;
        bus.ifun     = fn;
        bus.alu_cc   = a;
        bus.freeze   = frz;
        bus.err      = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #1;
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [0:2] hold_cc;
        n_checks = 0;
        n_pass   = 0;
        drive(1'b0, 4'h1, 4'h0, 3'b000, 1'b0, 1'b0);
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("por");

        // Disturb state, then assert reset away from any clock edge.
        drive(1'b1, 4'h6, 4'h3, 3'b011, 1'b0, 1'b0);
        step();
        step();
        check_all("pre_rst");
        drive(1'b0, 4'h1, 4'h3, 3'b000, 1'b0, 1'b0);
        #2;
        do_reset();
        check("rst.cnd_e", 32'(bus.cnd), 32'd1);
        check("rst.cc_lit", 32'(bus.cc), 32'h4);

        // OPq write latency and same-cycle condition using old flags.
        drive(1'b1, 4'h6, 4'h2, 3'b010, 1'b0, 1'b0);
        #1;
        check("lat.cnd_before", 32'(bus.cnd), 32'd0);
        step();
        check_all("lat.after");
        check("lat.cc_lit", 32'(bus.cc), 32'h2);
        check("lat.cnd_after", 32'(bus.cnd), 32'd1);
        drive(1'b0, 4'h1, 4'h2, 3'b000, 1'b0, 1'b0);
        step();
        check("lat.cc_wr_drop", 32'(bus.cc_wr), 32'd0);

        // Full flag x ifun sweep.
        for (int v = 0; v < 8; v++) begin
            drive(1'b1, 4'h6, 4'h0, 3'(v), 1'b0, 1'b0);
            step();
            drive(1'b0, 4'h1, 4'h0, 3'b000, 1'b0, 1'b0);
            for (int f = 0; f < 16; f++) begin
                bus.ifun = 4'(f);
                #1;
                check($sformatf("sweep.cc%0d.f%0d", v, f), 32'(bus.cnd),
                      32'(ref_cnd(m_zf, m_sf, m_of, f)));
            end
            step();
        end

        // Freeze suppresses only the current write.
        hold_cc = bus.cc;
        drive(1'b1, 4'h6, 4'h1, 3'b001, 1'b1, 1'b0);
        step();
        check_all("frz");
        check("frz.cc_hold", 32'(bus.cc), 32'(hold_cc));
        drive(1'b1, 4'h6, 4'h1, 3'b001, 1'b0, 1'b0);
        step();
        check_all("frz.next");
        check("frz.cc_lit", 32'(bus.cc), 32'h1);

        // Halt stops updates until reset.
        drive(1'b1, 4'h0, 4'h4, 3'b000, 1'b0, 1'b0);
        step();
        check_all("halt");
        check("halt.stopped", 32'(bus.stopped), 32'd1);
        drive(1'b1, 4'h6, 4'h5, 3'b000, 1'b0, 1'b0);
        step();
        check_all("halt.opq");
        check("halt.cc_lit", 32'(bus.cc), 32'h1);
        drive(1'b0, 4'h1, 4'h3, 3'b000, 1'b0, 1'b0);
        #2;
        do_reset();

        // Faulting OPq: no write, stop at the same edge.
        drive(1'b1, 4'h6, 4'h0, 3'b110, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'h6, 4'h0, 3'b011, 1'b0, 1'b1);
        step();
        check_all("err");
        check("err.cc_lit", 32'(bus.cc), 32'h6);
        check("err.stopped", 32'(bus.stopped), 32'd1);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [3:0] ic;
            sel = int'($urandom_range(0, 99));
            if (sel < 50)      ic = 4'h6;
            else if (sel < 53) ic = 4'h0;
            else               ic = 4'($urandom_range(1, 15));
            drive(1'($urandom_range(0, 3) != 0), ic, 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 49) == 0));
            step();
            check_all("rnd");
            if (m_stopped && ($urandom_range(0, 7) == 0)) begin
                drive(1'b0, 4'h1, 4'($urandom_range(0, 15)), 3'b000, 1'b0, 1'b0);
                #2;
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
